// File: rtl/aes_inv_cipher_if.sv
// Interface for the AES inverse cipher: start/data handshake plus round-key SRAM port.
interface aes_inv_cipher_if #(
  parameter int unsigned IDX_W = 4
);
  logic             en_i;
  logic [127:0]     data_i;
  logic [127:0]     rkey_i;
  logic [IDX_W-1:0] rkey_idx_o;
  logic [127:0]     data_o;
  logic             valid_o;
  logic             busy_o;

  // Requester side: issues blocks and serves the round-key SRAM.
  modport master (
    output en_i, data_i, rkey_i,
    input  rkey_idx_o, data_o, valid_o, busy_o
  );

  // Cipher side.
  modport slave (
    input  en_i, data_i, rkey_i,
    output rkey_idx_o, data_o, valid_o, busy_o
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched in descending order.
module aes_inv_cipher #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input logic            clk,
  input logic            reset,
  aes_inv_cipher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEY_WAIT, FIRST_ROUND, INV_ROUND} fsm_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i (FIPS order) lives at bits [8*(15-i) +: 8]; column c at [32*(3-c) +: 32].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(r+4*c)) +: 8] = INV_SBOX[s[8*(15-(r+4*((c-r+4)%4))) +: 8]];
      end
    end
    return o;
  endfunction

  // One column times {0e,0b,0d,09}, built from the x2/x4/x8 doubling chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int j = 0; j < 4; j++) begin
      a  = col[8*(3-j) +: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[j] = x8 ^ a;
      mb[j] = x8 ^ x2 ^ a;
      md[j] = x8 ^ x4 ^ a;
      me[j] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[32*(3-c) +: 32] = inv_mix_col(s[32*(3-c) +: 32]);
    return o;
  endfunction

  fsm_t             st_q, st_d;
  logic [127:0]     state_q, state_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     t;
  logic [IDX_W-1:0] rc_q, rc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      state_q <= '0;
      data_q  <= '0;
      rc_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      data_q  <= data_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, round datapath and key-address sequencing.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    data_d  = data_q;
    rc_d    = rc_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    t       = inv_shift_sub(state_q) ^ bus.rkey_i;
    unique case (st_q)
      IDLE: begin
        if (bus.en_i) begin
          state_d = bus.data_i;
          idx_d   = IDX_W'(NR);
          st_d    = KEY_WAIT;
        end
      end
      KEY_WAIT: begin
        idx_d = IDX_W'(NR - 1);
        st_d  = FIRST_ROUND;
      end
      FIRST_ROUND: begin
        state_d = state_q ^ bus.rkey_i;
        idx_d   = IDX_W'(NR - 2);
        rc_d    = IDX_W'(NR - 1);
        st_d    = INV_ROUND;
      end
      INV_ROUND: begin
        idx_d = (idx_q == '0) ? '0 : idx_q - IDX_W'(1);
        if (rc_q == '0) begin
          data_d  = t;
          state_d = t;
          valid_d = 1'b1;
          st_d    = IDLE;
        end else begin
          state_d = inv_mix(t);
          rc_d    = rc_q - IDX_W'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    busy_d = (st_d != IDLE);
  end

  assign bus.rkey_idx_o = idx_q;
  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: NR=10 and NR=14 instances, each fed by a round-key SRAM model.
module tb_aes_inv_cipher;

  localparam int NR10 = 10;
  localparam int NR14 = 14;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 0;
  logic rstq = 1'b0;

  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] rk_calc [0:15];
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];
  logic [127:0] q10 [$];
  logic [127:0] q14 [$];
  logic [127:0] last10, last14, exp10, exp14;
  logic         vprev10 = 1'b0;

  aes_inv_cipher_if #(.IDX_W(4)) bus10 ();
  aes_inv_cipher_if #(.IDX_W(4)) bus14 ();

  aes_inv_cipher #(.NR(NR10), .IDX_W(4)) dut10 (.clk(clk), .reset(reset), .bus(bus10.slave));
  aes_inv_cipher #(.NR(NR14), .IDX_W(4)) dut14 (.clk(clk), .reset(reset), .bus(bus14.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expanded-key SRAMs with one cycle of read latency.
  always @(posedge clk) begin
    bus10.rkey_i <= rk10[bus10.rkey_idx_o];
    bus14.rkey_i <= rk14[bus14.rkey_idx_o];
    rstq <= reset;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gm(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*(15-i) +: 8] = inv ? isb[s[8*(15-i) +: 8]] : sb[s[8*(15-i) +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*src)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3, k0, k1, k2, k3;
    {k0, k1, k2, k3} = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[32*(3-c) +: 32];
      o[32*(3-c) +: 32] = {gm(k0,a0) ^ gm(k1,a1) ^ gm(k2,a2) ^ gm(k3,a3),
                           gm(k3,a0) ^ gm(k0,a1) ^ gm(k1,a2) ^ gm(k2,a3),
                           gm(k2,a0) ^ gm(k3,a1) ^ gm(k0,a2) ^ gm(k1,a3),
                           gm(k1,a0) ^ gm(k2,a1) ^ gm(k3,a2) ^ gm(k0,a3)};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 key expansion into rk_calc; a 128-bit key sits in the top half of key.
  function automatic void expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_calc[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rk_calc[0];
    for (int r = 1; r < nr; r++) s = mix_cols(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk_calc[r];
    return shift_rows(sub_bytes(s, 0), 0) ^ rk_calc[nr];
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input int nr);
    logic [127:0] s;
    s = ct ^ rk_calc[nr];
    for (int r = nr - 1; r >= 1; r--) s = mix_cols(sub_bytes(shift_rows(s, 1), 1) ^ rk_calc[r], 1);
    return sub_bytes(shift_rows(s, 1), 1) ^ rk_calc[0];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor for NR=10: scoreboard pop on valid, single-cycle pulse, data_o held between results.
  always @(negedge clk) begin
    if (armed) begin
      if (bus10.valid_o) begin
        n_cmp++;
        if (q10.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid10 got=%h required=no_pulse", bus10.data_o);
        end else begin
          exp10 = q10.pop_front();
          if (bus10.data_o !== exp10) begin
            n_err++;
            $display("FAIL result10 got=%h required=%h", bus10.data_o, exp10);
          end
        end
        n_cmp++;
        if (vprev10) begin
          n_err++;
          $display("FAIL valid_width10 got=2+ cycles required=1 cycle");
        end
      end else if (!rstq) begin
        n_cmp++;
        if (bus10.data_o !== last10) begin
          n_err++;
          $display("FAIL data_hold10 got=%h required=%h", bus10.data_o, last10);
        end
      end
    end
    last10  = bus10.data_o;
    vprev10 = bus10.valid_o;
  end

  // Monitor for NR=14.
  always @(negedge clk) begin
    if (armed) begin
      if (bus14.valid_o) begin
        n_cmp++;
        if (q14.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid14 got=%h required=no_pulse", bus14.data_o);
        end else begin
          exp14 = q14.pop_front();
          if (bus14.data_o !== exp14) begin
            n_err++;
            $display("FAIL result14 got=%h required=%h", bus14.data_o, exp14);
          end
        end
      end else if (!rstq) begin
        n_cmp++;
        if (bus14.data_o !== last14) begin
          n_err++;
          $display("FAIL data_hold14 got=%h required=%h", bus14.data_o, last14);
        end
      end
    end
    last14 = bus14.data_o;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation from IDLE. k counts edges after the accepting edge (k=0 is that edge);
  // the final round lands on k=nr+2 and busy covers k=0..nr+1.
  task automatic op(input bit big, input logic [127:0] ct, input logic [127:0] pt, input bit detail);
    int nr, vk, nb;
    logic [127:0] idx, key;
    logic b, v;
    nr = big ? NR14 : NR10;
    if (big) begin bus14.en_i = 1'b1; bus14.data_i = ct; q14.push_back(pt); end
    else     begin bus10.en_i = 1'b1; bus10.data_i = ct; q10.push_back(pt); end
    step();
    if (big) begin bus14.en_i = 1'b0; bus14.data_i = ~ct; end
    else     begin bus10.en_i = 1'b0; bus10.data_i = ~ct; end
    vk = -1; nb = 0;
    for (int k = 0; k <= nr + 3; k++) begin
      if (k > 0) step();
      idx = big ? 128'(bus14.rkey_idx_o) : 128'(bus10.rkey_idx_o);
      key = big ? bus14.rkey_i : bus10.rkey_i;
      b   = big ? bus14.busy_o : bus10.busy_o;
      v   = big ? bus14.valid_o : bus10.valid_o;
      if (detail) begin
        chk($sformatf("rkey_idx_k%0d", k), idx, 128'((k <= nr) ? nr - k : 0));
        if (k == 1 && !big) chk("first_round_key", key, C1_RK10);
      end
      if (b) nb++;
      if (v && vk < 0) vk = k;
    end
    chk("valid_latency", 128'(vk), 128'(nr + 2));
    if (detail) chk("busy_cycles", 128'(nb), 128'(nr + 2));
  endtask

  initial begin
    logic [127:0] z_pt, key, pt;
    int vcnt, vk1, vk2, nb;

    for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    for (int i = 0; i < 16; i++) begin rk10[i] = '0; rk14[i] = '0; end

    reset = 1'b1;
    bus10.en_i = 1'b0; bus10.data_i = '0;
    bus14.en_i = 1'b0; bus14.data_i = '0;
    repeat (3) step();
    chk("rst_data_o", bus10.data_o, '0);
    chk("rst_valid_o", 128'(bus10.valid_o), '0);
    chk("rst_busy_o", 128'(bus10.busy_o), '0);
    chk("rst_rkey_idx_o", 128'(bus10.rkey_idx_o), '0);
    chk("rst_data_o14", bus14.data_o, '0);
    reset = 1'b0;
    armed = 1;
    step();

    // Reference model against FIPS-197 C.1 / C.3 before trusting it.
    expand({C1_KEY, 128'h0}, 4, NR10);
    chk("model_rk10", rk_calc[10], C1_RK10);
    chk("model_enc_c1", enc(C1_PT, NR10), C1_CT);
    for (int i = 0; i < 16; i++) rk10[i] = rk_calc[i];
    z_pt = dec('0, NR10);

    // C.1 with index sequence, first-round key and busy length.
    op(0, C1_CT, C1_PT, 1);

    // Back-to-back: en held high; second block accepted in the valid cycle.
    bus10.en_i = 1'b1; bus10.data_i = C1_CT;
    q10.push_back(C1_PT);
    q10.push_back(z_pt);
    step();
    bus10.data_i = '0;
    vcnt = 0; vk1 = -1; vk2 = -1;
    for (int k = 0; k <= 2 * (NR10 + 3) + 1; k++) begin
      if (k > 0) step();
      if (k == NR10 + 3) begin
        chk("second_accept_busy", 128'(bus10.busy_o), 128'(1));
        bus10.en_i = 1'b0;
        bus10.data_i = C1_CT;
      end
      if (bus10.valid_o) begin
        vcnt++;
        if (vk1 < 0) vk1 = k; else vk2 = k;
      end
    end
    chk("b2b_valid_count", 128'(vcnt), 128'(2));
    chk("b2b_first_valid", 128'(vk1), 128'(NR10 + 2));
    chk("b2b_valid_spacing", 128'(vk2 - vk1), 128'(NR10 + 3));

    // en toggled and data_i scrambled while busy: exactly one acceptance.
    bus10.en_i = 1'b1; bus10.data_i = '0;
    q10.push_back(z_pt);
    step();
    vcnt = 0; nb = 0;
    for (int k = 0; k <= 2 * (NR10 + 3); k++) begin
      if (k > 0) step();
      bus10.en_i   = (k >= 1 && k <= NR10) ? 1'(k % 2) : 1'b0;
      bus10.data_i = {4{$urandom}};
      if (bus10.valid_o) vcnt++;
      if (bus10.busy_o) nb++;
    end
    bus10.en_i = 1'b0;
    chk("toggle_valid_count", 128'(vcnt), 128'(1));
    chk("toggle_busy_cycles", 128'(nb), 128'(NR10 + 2));

    // Reset abort: reset sampled on the 6th edge after acceptance.
    bus10.en_i = 1'b1; bus10.data_i = C1_CT;
    step();
    bus10.en_i = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid_o", 128'(bus10.valid_o), '0);
    chk("abort_data_o", bus10.data_o, '0);
    chk("abort_busy_o", 128'(bus10.busy_o), '0);
    chk("abort_rkey_idx_o", 128'(bus10.rkey_idx_o), '0);
    vcnt = 0;
    for (int k = 0; k < NR10 + 4; k++) begin
      step();
      if (bus10.valid_o) vcnt++;
    end
    chk("abort_no_valid", 128'(vcnt), '0);
    op(0, C1_CT, C1_PT, 1);

    // NR=14 with FIPS-197 C.3.
    expand(C3_KEY, 8, NR14);
    chk("model_enc_c3", enc(C1_PT, NR14), C3_CT);
    for (int i = 0; i < 16; i++) rk14[i] = rk_calc[i];
    op(1, C3_CT, C1_PT, 1);

    // Round trip through the encryption model with random keys and blocks.
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand({key, 128'h0}, 4, NR10);
      for (int i = 0; i < 16; i++) rk10[i] = rk_calc[i];
      op(0, enc(pt, NR10), pt, 0);
    end

    repeat (3) step();
    chk("q10_drained", 128'(q10.size()), '0);
    chk("q14_drained", 128'(q14.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
